// File: rtl/flag_branch_ctrl_if.sv
// Pipeline-side bundle for flag_branch_ctrl: EX-stage ALU flag results,
// ID-stage B.cond request, and the resulting flag/branch/hazard outputs.
// master = pipeline driving EX/ID information, slave = flag/branch controller.
interface flag_branch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             ex_set_flags;
  logic             flush_ex;
  logic             alu_negative;
  logic             alu_zero;
  logic             alu_carry_out;
  logic             alu_overflow;
  logic             id_cond_valid;
  logic [3:0]       id_cond;
  logic [3:0]       nzcv;
  logic             branch_taken;
  logic             stall_req;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output stall, ex_set_flags, flush_ex,
    output alu_negative, alu_zero, alu_carry_out, alu_overflow,
    output id_cond_valid, id_cond,
    input  nzcv, branch_taken, stall_req, stall_count
  );

  modport slave (
    input  stall, ex_set_flags, flush_ex,
    input  alu_negative, alu_zero, alu_carry_out, alu_overflow,
    input  id_cond_valid, id_cond,
    output nzcv, branch_taken, stall_req, stall_count
  );
endinterface

// File: rtl/flag_branch_ctrl.sv
// flag_branch_ctrl: architectural NZCV register, B.cond resolution in ID and
// EX->ID flag hazard handling.
// Build option: define FLAG_FWD_EN to forward EX ALU flags straight into the
// ID condition decode; otherwise a hazard costs one IDLE->WAIT stall cycle.
module flag_branch_ctrl #(
  parameter logic [3:0] NZCV_RST = 4'b0000,
  parameter int         CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  flag_branch_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [3:0]       nzcv_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  logic [3:0]       alu_flags;
  logic             ex_writes;
  logic             hazard;
  logic             stall_req_int;
  logic [3:0]       eff_flags;
  logic             cond_true;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  assign alu_flags = {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};
  assign ex_writes = bus.ex_set_flags & ~bus.flush_ex;
  // AL/NV never read flags, so they cannot be stalled by an in-flight setter.
  assign hazard    = bus.id_cond_valid & ex_writes & (bus.id_cond[3:1] != 3'b111);

  // Architectural flag register: only a live (unflushed) setter updates it.
  always_ff @(posedge clk) begin
    if (reset) begin
      nzcv_reg <= NZCV_RST;
    end else if (ex_writes & ~bus.stall) begin
      nzcv_reg <= alu_flags;
    end
  end

  // Hazard FSM state and stall counter; frozen by the global pipeline stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else if (~bus.stall) begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

`ifdef FLAG_FWD_EN
  // Forwarding build: hazards never stall, so the FSM is parked in IDLE.
  always_comb begin
    state_next = IDLE;
    count_next = count_reg;
    if (state_reg == WAIT) begin
      state_next = IDLE;
    end
  end

  // Forwarding build: the hazard picks the EX flags, no stall request.
  always_comb begin
    stall_req_int = 1'b0;
    eff_flags     = hazard ? alu_flags : nzcv_reg;
  end
`else
  // Stall build: a hazard in IDLE costs exactly one WAIT cycle; WAIT never re-stalls.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (hazard) begin
          state_next = WAIT;
          if (count_reg != {CNT_W{1'b1}}) begin
            count_next = count_reg + CNT_W'(1);
          end
        end
      end
      WAIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Stall build: request a hold only from IDLE; decode always reads the register.
  always_comb begin
    stall_req_int = (state_reg == IDLE) & hazard & ~reset;
    eff_flags     = nzcv_reg;
  end
`endif

  assign {flag_n, flag_z, flag_c, flag_v} = eff_flags;

  // ARM condition-code evaluation on the effective flags.
  always_comb begin
    cond_true = 1'b0;
    case (bus.id_cond)
      4'b0000: cond_true = flag_z;                          // EQ
      4'b0001: cond_true = ~flag_z;                         // NE
      4'b0010: cond_true = flag_c;                          // HS
      4'b0011: cond_true = ~flag_c;                         // LO
      4'b0100: cond_true = flag_n;                          // MI
      4'b0101: cond_true = ~flag_n;                         // PL
      4'b0110: cond_true = flag_v;                          // VS
      4'b0111: cond_true = ~flag_v;                         // VC
      4'b1000: cond_true = flag_c & ~flag_z;                // HI
      4'b1001: cond_true = ~flag_c | flag_z;                // LS
      4'b1010: cond_true = (flag_n == flag_v);              // GE
      4'b1011: cond_true = (flag_n != flag_v);              // LT
      4'b1100: cond_true = ~flag_z & (flag_n == flag_v);    // GT
      4'b1101: cond_true = flag_z | (flag_n != flag_v);     // LE
      4'b1110: cond_true = 1'b1;                            // AL
      4'b1111: cond_true = 1'b1;                            // NV behaves as AL
      default: cond_true = 1'b0;
    endcase
  end

  assign bus.nzcv         = nzcv_reg;
  assign bus.stall_req    = stall_req_int;
  assign bus.stall_count  = count_reg;
  // A stalled branch is resolved in the following cycle, never while stalling.
  assign bus.branch_taken = ~reset & bus.id_cond_valid & ~stall_req_int & cond_true;

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Self-checking bench for flag_branch_ctrl: a flag/hazard reference model
// checked every cycle, plus hand-computed literal expectations.
// Honours FLAG_FWD_EN the same way the design does.
module tb_flag_branch_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  localparam logic [3:0] C_EQ = 4'b0000;
  localparam logic [3:0] C_NE = 4'b0001;
  localparam logic [3:0] C_MI = 4'b0100;
  localparam logic [3:0] C_AL = 4'b1110;

`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  flag_branch_ctrl_if #(.CNT_W(CNT_W)) bus ();

  flag_branch_ctrl #(
    .NZCV_RST(4'b0000),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int  m_nzcv    = 0;
  bit  m_waiting = 1'b0;
  int  m_count   = 0;
  bit  started   = 1'b0;

  // ARM ConditionHolds(): evaluate the base test, invert for odd codes except 1111.
  function automatic bit cond_holds(input int cond, input int flags);
    bit n, z, c, v, r;
    n = flags[3]; z = flags[2]; c = flags[1]; v = flags[0];
    case (cond / 2)
      0: r = z;
      1: r = c;
      2: r = n;
      3: r = v;
      4: r = c && !z;
      5: r = (n == v);
      6: r = (n == v) && !z;
      default: r = 1'b1;
    endcase
    if ((cond % 2 == 1) && (cond != 15)) r = !r;
    return r;
  endfunction

  function automatic int cur_alu();
    return {28'd0, bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};
  endfunction

  function automatic bit cur_hazard();
    return bus.id_cond_valid && bus.ex_set_flags && !bus.flush_ex && (int'(bus.id_cond) < 14);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model advance on each clock edge, from the inputs presented before the edge.
  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      m_nzcv    = 0;
      m_waiting = 1'b0;
      m_count   = 0;
    end else if (!bus.stall) begin
      if (bus.ex_set_flags && !bus.flush_ex) m_nzcv = cur_alu();
      if (!FWD) begin
        if (m_waiting) m_waiting = 1'b0;
        else if (cur_hazard()) begin
          m_waiting = 1'b1;
          if (m_count < CNT_MAX) m_count = m_count + 1;
        end
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      int exp_sreq;
      int eff;
      int exp_taken;
      exp_sreq  = (!FWD && !reset && !m_waiting && cur_hazard()) ? 1 : 0;
      eff       = (FWD && cur_hazard()) ? cur_alu() : m_nzcv;
      exp_taken = (!reset && bus.id_cond_valid && exp_sreq == 0 &&
                   cond_holds(int'(bus.id_cond), eff)) ? 1 : 0;
      chk("model_nzcv",        int'(bus.nzcv),        m_nzcv);
      chk("model_stall_req",   int'(bus.stall_req),   exp_sreq);
      chk("model_taken",       int'(bus.branch_taken), exp_taken);
      chk("model_stall_count", int'(bus.stall_count), m_count);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rst, input logic st, input logic set, input logic fl,
                       input logic [3:0] f, input logic cv, input logic [3:0] cond);
    @(posedge clk);
    #1;
    reset             = rst;
    bus.stall         = st;
    bus.ex_set_flags  = set;
    bus.flush_ex      = fl;
    {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow} = f;
    bus.id_cond_valid = cv;
    bus.id_cond       = cond;
    txn++;
    $display("txn %0d: rst=%0b stall=%0b set=%0b flush=%0b alu=%b cv=%0b cond=%b",
             txn, rst, st, set, fl, f, cv, cond);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000);
  endtask

  initial begin
    reset             = 1'b1;
    bus.stall         = 1'b0;
    bus.ex_set_flags  = 1'b0;
    bus.flush_ex      = 1'b0;
    bus.alu_negative  = 1'b0;
    bus.alu_zero      = 1'b0;
    bus.alu_carry_out = 1'b0;
    bus.alu_overflow  = 1'b0;
    bus.id_cond_valid = 1'b0;
    bus.id_cond       = 4'b0000;

    // Reset for two cycles with a B.AL presented: nothing may be taken.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, C_AL);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, C_AL);
    #2;
    chk("rst_nzcv",      int'(bus.nzcv),         0);
    chk("rst_stall_req", int'(bus.stall_req),    0);
    chk("rst_count",     int'(bus.stall_count),  0);
    chk("rst_taken",     int'(bus.branch_taken), 0);

    // SUBS producing Z=1,C=1, then B.EQ one cycle later: no hazard, taken.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, C_EQ);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, C_EQ);
    #2;
    chk("subs_nzcv",  int'(bus.nzcv),         6);
    chk("subs_taken", int'(bus.branch_taken), 1);

    // Clear flags, then SUBS Z=1 in EX together with B.EQ in ID.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, C_EQ);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b1, C_EQ);
    #2;
    chk("haz_stall_req", int'(bus.stall_req),    FWD ? 0 : 1);
    chk("haz_taken",     int'(bus.branch_taken), FWD ? 1 : 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, C_EQ);
    #2;
    chk("haz_next_taken", int'(bus.branch_taken), 1);
    chk("haz_count",      int'(bus.stall_count),  FWD ? 0 : 1);
    idle();

    // Flushed setter with N=1 alongside B.MI: old N=0 decides, nzcv unchanged.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b1, C_MI);
    #2;
    chk("flush_stall_req", int'(bus.stall_req),    0);
    chk("flush_taken",     int'(bus.branch_taken), 0);
    idle();
    #2;
    chk("flush_nzcv", int'(bus.nzcv), 4);

    // Global stall during a hazard: everything frozen, stall_req still driven.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, C_EQ);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, C_EQ);
    #2;
    chk("frz_nzcv",      int'(bus.nzcv),        4);
    chk("frz_count",     int'(bus.stall_count), FWD ? 0 : 1);
    chk("frz_stall_req", int'(bus.stall_req),   FWD ? 0 : 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, C_EQ);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, C_EQ);
    idle();

    // B.AL with a setter in EX is not a hazard.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, C_AL);
    #2;
    chk("al_stall_req", int'(bus.stall_req),    0);
    chk("al_taken",     int'(bus.branch_taken), 1);

    // Reset while waiting: back to IDLE with reset flags.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 1'b1, C_NE);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, C_NE);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, C_NE);
    #2;
    chk("rstw_taken", int'(bus.branch_taken), 1);
    chk("rstw_count", int'(bus.stall_count),  0);

    // Sweep every flag pattern against every condition, hazard then bubble.
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'(f), 1'b1, 4'(c));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'(c));
      end
    end

    // Counter saturation: 20 hazards from reset.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, C_EQ);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'(i), 1'b1, 4'(i % 14));
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, C_EQ);
    end
    #2;
    chk("sat_count", int'(bus.stall_count), FWD ? 0 : 15);
    idle();
    idle();

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
